// File: rtl/link_order_arbiter.sv
// Round-robin arbiter sharing one link table manager order/dout port pair among NUM_REQ requesters.
// Optional per-requester grant statistics are enabled with `define LINK_ARB_STAT_EN.
module link_order_arbiter #(
  parameter int         NUM_REQ       = 4,
  parameter int         ADDR_WIDTH    = 16,
  parameter int         DATA_WIDTH    = 16,
  parameter int         TABLE_WIDTH   = 8,
  parameter logic [3:0] RSP_TYPE_MASK = 4'b0010,
  parameter int         TAG_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_busy,
  input  logic [2*NUM_REQ-1:0]           req_type,
  input  logic [TABLE_WIDTH*NUM_REQ-1:0] req_table,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_node,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
  output logic                           m_order_valid,
  input  logic                           m_order_busy,
  output logic [1:0]                     m_order_type,
  output logic [TABLE_WIDTH-1:0]         m_order_table,
  output logic [ADDR_WIDTH-1:0]          m_order_node,
  output logic [DATA_WIDTH-1:0]          m_order_data,
  input  logic                           m_dout_valid,
  output logic                           m_dout_busy,
  input  logic [DATA_WIDTH-1:0]          m_dout_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_busy,
  output logic [DATA_WIDTH-1:0]          rsp_data
`ifdef LINK_ARB_STAT_EN
  ,
  input  logic [2:0]                     stat_sel,
  output logic [15:0]                    stat_count
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic                     valid_q, valid_d;
  logic [1:0]               type_q, type_d;
  logic [TABLE_WIDTH-1:0]   table_q, table_d;
  logic [ADDR_WIDTH-1:0]    node_q, node_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  logic [IW-1:0]            tag_mem_q [TAG_DEPTH];
  logic [AW:0]              wr_ptr_q, rd_ptr_q;
  logic                     fifo_empty_s, fifo_full_s, push_s, pop_s;
  logic [IW-1:0]            head_s;

  logic [1:0]               type_a   [NUM_REQ];
  logic [TABLE_WIDTH-1:0]   table_a  [NUM_REQ];
  logic [ADDR_WIDTH-1:0]    node_a   [NUM_REQ];
  logic [DATA_WIDTH-1:0]    data_a   [NUM_REQ];
  logic [NUM_REQ-1:0]       eligible_s;
  logic                     grant_found_s;
  logic [IW-1:0]            grant_idx_s;
  logic [NUM_REQ-1:0]       req_busy_s;
  logic [NUM_REQ-1:0]       rsp_valid_s;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_s       = tag_mem_q[rd_ptr_q[AW-1:0]];

  // Unpack the per-requester buses and decide who may be granted this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      type_a[i]     = req_type[2*i +: 2];
      table_a[i]    = req_table[TABLE_WIDTH*i +: TABLE_WIDTH];
      node_a[i]     = req_node[ADDR_WIDTH*i +: ADDR_WIDTH];
      data_a[i]     = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      // Full FIFO blocks response-producing orders even if a pop happens now.
      eligible_s[i] = req_valid[i] && (!RSP_TYPE_MASK[type_a[i]] || !fifo_full_s);
    end
  end

  // Round-robin search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!grant_found_s && eligible_s[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IW'(cand);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Order-channel FSM next state, output stage load and requester handshakes.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    type_d     = type_q;
    table_d    = table_q;
    node_d     = node_q;
    data_d     = data_q;
    req_busy_s = '1;
    push_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          req_busy_s[grant_idx_s] = 1'b0;
          type_d  = type_a[grant_idx_s];
          table_d = table_a[grant_idx_s];
          node_d  = node_a[grant_idx_s];
          data_d  = data_a[grant_idx_s];
          valid_d = 1'b1;
          ptr_d   = (grant_idx_s == IW'(NUM_REQ - 1)) ? '0 : grant_idx_s + IW'(1);
          push_s  = RSP_TYPE_MASK[type_a[grant_idx_s]];
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!m_order_busy) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Response steering to the requester at the head of the tag FIFO.
  always_comb begin
    rsp_valid_s = '0;
    if (rst_n && m_dout_valid && !fifo_empty_s) begin
      rsp_valid_s[head_s] = 1'b1;
    end else begin
      rsp_valid_s = '0;
    end
  end

  assign m_dout_busy   = !rst_n || fifo_empty_s || rsp_busy[head_s];
  assign pop_s         = m_dout_valid && !m_dout_busy;
  assign rsp_valid     = rsp_valid_s;
  assign rsp_data      = m_dout_data;
  assign req_busy      = rst_n ? req_busy_s : '1;
  assign m_order_valid = valid_q;
  assign m_order_type  = type_q;
  assign m_order_table = table_q;
  assign m_order_node  = node_q;
  assign m_order_data  = data_q;

  // State, pointer, output stage and FIFO pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      type_q   <= 2'd0;
      table_q  <= '0;
      node_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      type_q   <= type_d;
      table_q  <= table_d;
      node_q   <= node_d;
      data_q   <= data_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Tag storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_q[wr_ptr_q[AW-1:0]] <= grant_idx_s;
    end
  end

`ifdef LINK_ARB_STAT_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] stat_q;

  // Saturating grant counters and registered counter readback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= 16'h0000;
      stat_q <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((state_q == S_IDLE) && grant_found_s && (grant_idx_s == IW'(i)) && (cnt_q[i] != 16'hFFFF))
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
      stat_q <= (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : 16'h0000;
    end
  end

  assign stat_count = stat_q;
`endif

endmodule
